ccff_bitstream_loader: RTL and testbench

- Upstream driver for the configuration-chain ports of the I/O and logic tiles (ccff_head, config_enable).
- Accepts bitstream words from the SoC/test host through a valid/ready stream and serialises them onto ccff_head, MSB first.
- Prepends an 8-bit marker. It then checks the marker as it emerges from ccff_tail, which confirms chain length and integrity.
- Reports busy/done/error to the host.

---
 rtl/ccff_bitstream_loader.sv | 169 ++++++++++++++++
 tb/tb_ccff_bitstream_loader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain loader: serialises a marker plus bitstream words
// onto ccff_head and verifies the marker as it emerges at ccff_tail.
module ccff_bitstream_loader #(
  parameter int         CHAIN_LEN = 1024,
  parameter int         WORD_W    = 8,
  parameter logic [7:0] MARKER    = 8'hA5,
  parameter int         CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              ccff_head,
  output logic              config_enable,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int BI_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] CL = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] NW = CNT_W'(CHAIN_LEN / WORD_W);
  localparam logic [BI_W-1:0] LAST = BI_W'(WORD_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MARK,
    S_LOAD,
    S_DONE,
    S_ERR
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  words_q, words_d;
  logic [WORD_W-1:0] buf_q, buf_d;
  logic              bvld_q, bvld_d;
  logic [BI_W-1:0]   bidx_q, bidx_d;
  logic              head_q, head_d;
  logic              cen_q, cen_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic       accept;
  logic       take;
  logic       chk;
  logic       mism;
  logic [2:0] k;

  assign busy     = (state_q == S_MARK) || (state_q == S_LOAD);
  assign bs_ready = busy && !bvld_q && (words_q < NW);
  assign accept   = bs_valid && bs_ready;

  // Marker bit k reaches the tail once CHAIN_LEN+k shifts are done
  assign k    = 3'(cnt_q - CL);
  assign chk  = (state_q == S_LOAD) && (cnt_q >= CL)
             && (cnt_q < CL + CNT_W'(8));
  assign mism = chk && (ccff_tail != MARKER[3'd7 - k]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    words_d = words_q;
    buf_d   = buf_q;
    bvld_d  = bvld_q;
    bidx_d  = bidx_q;
    head_d  = head_q;
    cen_d   = 1'b0;
    done_d  = done_q;
    err_d   = err_q;
    take    = 1'b0;

    if (cen_q) cnt_d = cnt_q + CNT_W'(1);

    if (accept) begin
      buf_d   = bs_data;
      bvld_d  = 1'b1;
      bidx_d  = '0;
      words_d = words_q + CNT_W'(1);
    end

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_MARK;
          cnt_d   = '0;
          words_d = '0;
          bvld_d  = 1'b0;
          bidx_d  = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          cen_d   = 1'b1;
          head_d  = MARKER[7];
        end
      end
      S_MARK: begin
        if (cnt_q == CNT_W'(7)) begin
          state_d = S_LOAD;
          take    = 1'b1;
        end else begin
          cen_d  = 1'b1;
          head_d = MARKER[3'd6 - cnt_q[2:0]];
        end
      end
      S_LOAD: begin
        if (mism) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else if (cen_q && cnt_q == CL + CNT_W'(7)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          take = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A word arriving on an empty buffer is presented on the same edge
    if (take) begin
      if (bvld_q) begin
        cen_d  = 1'b1;
        head_d = buf_q[LAST - bidx_q];
        bidx_d = bidx_q + BI_W'(1);
        if (bidx_q == LAST) bvld_d = 1'b0;
      end else if (accept) begin
        cen_d  = 1'b1;
        head_d = bs_data[WORD_W-1];
        bidx_d = BI_W'(1);
        bvld_d = (WORD_W > 1);
      end
    end
  end

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      words_q <= '0;
      buf_q   <= '0;
      bvld_q  <= 1'b0;
      bidx_q  <= '0;
      head_q  <= 1'b0;
      cen_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      words_q <= words_d;
      buf_q   <= buf_d;
      bvld_q  <= bvld_d;
      bidx_q  <= bidx_d;
      head_q  <= head_d;
      cen_q   <= cen_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign ccff_head     = head_q;
  assign config_enable = cen_q;
  assign done          = done_q;
  assign error         = err_q;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: 16-flop chain model, scoreboarded
// shift stream and per-load result checks.
module tb_ccff_bitstream_loader;

  localparam int CL = 16;

  logic       prog_clk = 1'b0;
  logic       pReset_n = 1'b0;
  logic       start    = 1'b0;
  logic [7:0] bs_data  = 8'h00;
  logic       bs_valid = 1'b0;
  logic       bs_ready;
  logic       ccff_head;
  logic       config_enable;
  logic       ccff_tail;
  logic       busy;
  logic       done;
  logic       error;

  ccff_bitstream_loader #(
    .CHAIN_LEN(CL),
    .WORD_W   (8),
    .MARKER   (8'hA5),
    .CNT_W    (16)
  ) dut (
    .prog_clk     (prog_clk),
    .pReset_n     (pReset_n),
    .start        (start),
    .bs_data      (bs_data),
    .bs_valid     (bs_valid),
    .bs_ready     (bs_ready),
    .ccff_head    (ccff_head),
    .config_enable(config_enable),
    .ccff_tail    (ccff_tail),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  always #5 prog_clk = ~prog_clk;

  // Behavioural chain: length selectable (16 or 15), tail can be stuck
  logic [15:0] chain;
  int          chain_len = 16;
  bit          stuck     = 1'b0;

  always @(posedge prog_clk)
    if (config_enable) chain <= {chain[14:0], ccff_head};

  assign ccff_tail = stuck ? 1'b0 : chain[chain_len-1];

  typedef struct {
    bit          err;
    int          shifts;
    int          bubbles;
    logic [15:0] chain;
  } res_t;

  bit   exp_bits[$];
  res_t exp_res[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void miss(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: no expected entry queued", nm);
  endfunction

  // Monitor: pops one expected bit per shift, one result per completion
  initial begin
    int   m_shifts;
    int   m_bub;
    bit   busy_p;
    bit   fin_p;
    bit   b;
    res_t r;
    m_shifts = 0;
    m_bub    = 0;
    busy_p   = 1'b0;
    fin_p    = 1'b0;
    forever begin
      @(negedge prog_clk);
      if (pReset_n) begin
        if (busy && !busy_p) begin
          m_shifts = 0;
          m_bub    = 0;
        end
        if (config_enable) begin
          m_shifts++;
          if (exp_bits.size() == 0) miss("head");
          else begin
            b = exp_bits.pop_front();
            chk("head", ccff_head, b);
          end
        end
        if (busy && !config_enable) m_bub++;
        if ((done || error) && !fin_p) begin
          if (exp_res.size() == 0) miss("result");
          else begin
            r = exp_res.pop_front();
            chk("error", error, r.err);
            chk("done", done, !r.err);
            if (!r.err) begin
              chk("chain", chain, r.chain);
              chk("shifts", m_shifts, r.shifts);
              chk("bubbles", m_bub, r.bubbles);
            end
          end
        end
      end
      busy_p = busy;
      fin_p  = done || error;
    end
  end

  task automatic run_load(input logic [7:0] w0, input logic [7:0] w1,
                          input int g0, input int g1,
                          input int len, input bit stk,
                          input int abort_at, input int start_at);
    bit         s[$];
    logic [7:0] mk;
    logic [7:0] w [2];
    int         gap [2];
    bit         tb_bit;
    bit         err;
    res_t       r;
    int         nsh;
    int         wi;
    int         cnt;
    bit         armed;
    bit         fin;
    bit         inj;

    mk = 8'hA5;
    w[0] = w0;
    w[1] = w1;
    gap[0] = g0;
    gap[1] = g1;
    chain_len = len;
    stuck = stk;

    for (int i = 7; i >= 0; i--) s.push_back(mk[i]);
    for (int j = 0; j < 2; j++)
      for (int i = 7; i >= 0; i--) s.push_back(w[j][i]);

    // Marker bit k is read back after CL+k shifts from a len-flop chain
    err = 1'b0;
    for (int kk = 0; kk < 8; kk++) begin
      tb_bit = stk ? 1'b0 : s[CL + kk - len];
      if (tb_bit != s[kk]) err = 1'b1;
    end
    r.err     = err;
    r.chain   = {w0, w1};
    r.shifts  = CL + 8;
    r.bubbles = ((g0 > 7) ? g0 - 7 : 0) + g1;
    foreach (s[i]) exp_bits.push_back(s[i]);
    exp_res.push_back(r);

    @(negedge prog_clk);
    start = 1'b1;
    nsh   = 0;
    wi    = 0;
    cnt   = 0;
    armed = 1'b0;
    fin   = 1'b0;
    inj   = 1'b0;

    for (int t = 0; t < 400; t++) begin
      @(negedge prog_clk);
      start = 1'b0;
      if (done || error) begin
        fin = 1'b1;
        break;
      end
      if (config_enable) nsh++;
      if (abort_at >= 0 && nsh == abort_at) begin
        #2 pReset_n = 1'b0;
        #1;
        chk("rst_cen", config_enable, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", bs_ready, 1'b0);
        chk("rst_head", ccff_head, 1'b0);
        exp_bits.delete();
        exp_res.delete();
        bs_valid = 1'b0;
        @(negedge prog_clk);
        pReset_n = 1'b1;
        return;
      end
      if (start_at >= 0 && nsh == start_at && !inj) begin
        start = 1'b1;
        inj   = 1'b1;
      end
      bs_valid = 1'b0;
      if (wi < 2) begin
        if (bs_ready && !armed) begin
          armed = 1'b1;
          cnt   = gap[wi];
        end
        if (gap[wi] == 0 || (armed && cnt == 0)) begin
          bs_valid = 1'b1;
          bs_data  = w[wi];
          if (bs_ready) begin
            wi++;
            armed = 1'b0;
          end
        end else if (armed) begin
          cnt--;
        end
      end
    end

    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL timeout: load did not finish, shifts=%0d", nsh);
      exp_res.delete();
    end

    // Words offered after completion must be refused
    bs_valid = 1'b1;
    bs_data  = 8'hFF;
    @(negedge prog_clk);
    @(negedge prog_clk);
    chk("post_ready", bs_ready, 1'b0);
    chk("post_busy", busy, 1'b0);
    chk("post_cen", config_enable, 1'b0);
    if (!err) chk("bits_left", exp_bits.size(), 0);
    exp_bits.delete();
    bs_valid = 1'b0;
  endtask

  initial begin
    #12;
    chk("reset_head", ccff_head, 1'b0);
    chk("reset_cen", config_enable, 1'b0);
    chk("reset_ready", bs_ready, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_error", error, 1'b0);
    @(negedge prog_clk);
    pReset_n = 1'b1;

    run_load(8'h3C, 8'hF0, 0, 0, 16, 1'b0, -1, -1);
    run_load(8'h3C, 8'hF0, 0, 5, 16, 1'b0, -1, -1);
    run_load(8'($urandom), 8'($urandom), 0, 0, 15, 1'b0, -1, -1);
    chk("err_ready", bs_ready, 1'b0);
    run_load(8'($urandom), 8'($urandom), 0, 0, 16, 1'b1, -1, -1);
    run_load(8'h3C, 8'hF0, 0, 0, 16, 1'b0, 10, -1);
    run_load(8'h96, 8'h0F, 0, 0, 16, 1'b0, -1, -1);
    run_load(8'h3C, 8'hF0, 0, 0, 16, 1'b0, -1, 12);
    run_load(8'h5A, 8'h5A, 0, 0, 16, 1'b0, -1, -1);

    for (int n = 0; n < 20; n++) begin
      int sel;
      sel = int'($urandom_range(0, 7));
      run_load(8'($urandom), 8'($urandom),
               int'($urandom_range(0, 10)),
               int'($urandom_range(0, 6)),
               (sel == 0) ? 15 : 16, sel == 1, -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
